// File: rtl/ps_pwrok_pkg.sv
// Shared state and fault-code encodings for the PSU PWROK qualifier.
package ps_pwrok_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        DLY   = 3'd2,
        ON    = 3'd3,
        FAULT = 3'd4
    } pwrok_state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_TIMEOUT = 2'b01,
        FLT_DROP    = 2'b10
    } pwrok_fault_e;

endpackage

// File: rtl/pwrok_debounce.sv
// Synchronizes the raw PSU PWROK and debounces it into a qualified level.
// Optional low-glitch filter is enabled by PS_PWROK_GLITCH_FILTER_EN.
module pwrok_debounce #(
    parameter int DEBOUNCE_MS = 2
`ifdef PS_PWROK_GLITCH_FILTER_EN
   ,parameter int GLITCH_CLKS = 4
`endif
) (
    input  logic iClk,
    input  logic iRst,
    input  logic i1mSCE,
    input  logic iRaw,
    output logic oLevel
);

    localparam int DW = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
    localparam logic [DW-1:0] DEB_TICKS = DW'(DEBOUNCE_MS);

    logic          meta_r;
    logic          sync_r;
    logic          level_r;
    logic [DW-1:0] tick_cnt_r;
    logic [DW-1:0] tick_cnt_s;
    logic          rise_s;
    logic          fall_s;

    // Two-flop synchronizer for the asynchronous PSU signal.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= iRaw;
            sync_r <= meta_r;
        end
    end

    // Count consecutive high ms ticks; any low sample restarts the count.
    always_comb begin
        tick_cnt_s = tick_cnt_r;
        if (!sync_r) begin
            tick_cnt_s = {DW{1'b0}};
        end else if (i1mSCE && (tick_cnt_r != DEB_TICKS)) begin
            tick_cnt_s = tick_cnt_r + DW'(1'b1);
        end else begin
            tick_cnt_s = tick_cnt_r;
        end
        rise_s = sync_r && i1mSCE && (tick_cnt_s == DEB_TICKS);
    end

    // Tick counter register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            tick_cnt_r <= {DW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_s;
        end
    end

`ifdef PS_PWROK_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CLKS + 1);
    localparam logic [GW-1:0] GLITCH_MAX  = GW'(GLITCH_CLKS);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CLKS - 1);

    logic [GW-1:0] low_cnt_r;

    // Count consecutive low cycles so that short dropouts are ignored.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            low_cnt_r <= {GW{1'b0}};
        end else if (sync_r) begin
            low_cnt_r <= {GW{1'b0}};
        end else if (low_cnt_r != GLITCH_MAX) begin
            low_cnt_r <= low_cnt_r + GW'(1'b1);
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    assign fall_s = !sync_r && (low_cnt_r >= GLITCH_LAST);
`else
    assign fall_s = !sync_r;
`endif

    // Qualified level: a drop always wins over a rise.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            level_r <= 1'b0;
        end else if (fall_s) begin
            level_r <= 1'b0;
        end else if (rise_s) begin
            level_r <= 1'b1;
        end else begin
            level_r <= level_r;
        end
    end

    assign oLevel = level_r;

endmodule

// File: rtl/ps_pwrok_qualifier.sv
// Qualifies PSU PWROK into PWRGD_PS_PWROK_DLY with timeout and drop-in-S0 fault latching.
// Optional PWROK low-glitch filter: define PS_PWROK_GLITCH_FILTER_EN.
module ps_pwrok_qualifier
    import ps_pwrok_pkg::*;
#(
    parameter int DEBOUNCE_MS = 2,
    parameter int DELAY_MS    = 100,
    parameter int TIMEOUT_MS  = 1000
`ifdef PS_PWROK_GLITCH_FILTER_EN
   ,parameter int GLITCH_CLKS = 4
`endif
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       i1mSCE,
    input  logic       iPsEn,
    input  logic       FM_SLPS3_N,
    input  logic       PWRGD_PS_PWROK,
    input  logic       iFaultClr,
    output logic       PWRGD_PS_PWROK_DLY,
    output logic       oPsFault,
    output logic [1:0] ovFaultCode,
    output logic [2:0] ovState
);

    localparam int CW = $clog2(TIMEOUT_MS + 1);
    localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT_MS);
    localparam logic [CW-1:0] DLY_CNT = CW'(DELAY_MS);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    pwrok_state_e  state_r;
    pwrok_state_e  next_s;
    pwrok_fault_e  code_r;
    pwrok_fault_e  evt_code_s;
    logic          evt_s;
    logic          fault_r;
    logic          pwrok_dly_r;
    logic          db_pwrok_s;
    logic [CW-1:0] ms_cnt_r;

    pwrok_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
`ifdef PS_PWROK_GLITCH_FILTER_EN
       ,.GLITCH_CLKS (GLITCH_CLKS)
`endif
    ) u_debounce (
        .iClk   (iClk),
        .iRst   (iRst),
        .i1mSCE (i1mSCE),
        .iRaw   (PWRGD_PS_PWROK),
        .oLevel (db_pwrok_s)
    );

    // Next-state and fault-event decode; iPsEn removal always wins.
    always_comb begin
        next_s     = state_r;
        evt_s      = 1'b0;
        evt_code_s = FLT_NONE;
        case (state_r)
            IDLE: begin
                if (iPsEn) next_s = WAIT;
                else       next_s = IDLE;
            end
            WAIT: begin
                if (!iPsEn) begin
                    next_s = IDLE;
                end else if (db_pwrok_s) begin
                    next_s = DLY;
                end else if (ms_cnt_r == TMO_CNT) begin
                    next_s     = FAULT;
                    evt_s      = 1'b1;
                    evt_code_s = FLT_TIMEOUT;
                end else begin
                    next_s = WAIT;
                end
            end
            DLY: begin
                if (!iPsEn)                   next_s = IDLE;
                else if (!db_pwrok_s)         next_s = WAIT;
                else if (ms_cnt_r == DLY_CNT) next_s = ON;
                else                          next_s = DLY;
            end
            ON: begin
                if (!iPsEn) begin
                    next_s = IDLE;
                end else if (!db_pwrok_s && FM_SLPS3_N) begin
                    next_s     = FAULT;
                    evt_s      = 1'b1;
                    evt_code_s = FLT_DROP;
                end else if (!db_pwrok_s) begin
                    next_s = IDLE;
                end else begin
                    next_s = ON;
                end
            end
            FAULT: begin
                if (!iPsEn) next_s = IDLE;
                else        next_s = FAULT;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register and qualified output; output is high only while staying in ON.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r     <= IDLE;
            pwrok_dly_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            pwrok_dly_r <= (state_r == ON) && (next_s == ON);
        end
    end

    // Saturating ms counter, restarted on every state change.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ms_cnt_r <= {CW{1'b0}};
        end else if (next_s != state_r) begin
            ms_cnt_r <= {CW{1'b0}};
        end else if (i1mSCE && (ms_cnt_r != CNT_MAX)) begin
            ms_cnt_r <= ms_cnt_r + CW'(1'b1);
        end else begin
            ms_cnt_r <= ms_cnt_r;
        end
    end

    // Sticky fault latch; a new event beats a concurrent clear.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fault_r <= 1'b0;
            code_r  <= FLT_NONE;
        end else if (evt_s) begin
            fault_r <= 1'b1;
            code_r  <= evt_code_s;
        end else if (iFaultClr) begin
            fault_r <= 1'b0;
            code_r  <= FLT_NONE;
        end else begin
            fault_r <= fault_r;
            code_r  <= code_r;
        end
    end

    assign PWRGD_PS_PWROK_DLY = pwrok_dly_r;
    assign oPsFault           = fault_r;
    assign ovFaultCode        = code_r;
    assign ovState            = state_r;

endmodule
